// File: rtl/labyrinth_pkg.sv
// Purpose: shared constants, FSM encoding and axis-step helper for the labyrinth ball engine.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package labyrinth_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int MAP_COLS = 40;
    localparam int MAP_ROWS = 30;

    localparam logic [1:0] TILE_FLOOR = 2'd0;
    localparam logic [1:0] TILE_WALL  = 2'd1;
    localparam logic [1:0] TILE_HOLE  = 2'd2;
    localparam logic [1:0] TILE_GOAL  = 2'd3;

    typedef enum logic [3:0] {
        IDLE, VEL, QX0, QX1, WX, QY0, QY1, WY, QC, RC, DONE
    } state_t;

    // Adds a signed velocity to a 10.4 position and clamps to [0, hi].
    // Result is {clamped, position}. One extra bit above the 14-bit
    // position is needed: the right bound (632<<4) already uses bit 13,
    // so a plain 14-bit signed sum would wrap.
    function automatic logic [14:0] axis_step(input logic [13:0] pos,
                                              input logic [9:0]  vel,
                                              input logic [13:0] hi);
        logic signed [14:0] sum;
        sum = $signed({1'b0, pos}) + $signed({{5{vel[9]}}, vel});
        if (sum[14])
            return {1'b1, 14'd0};
        else if (sum[13:0] > hi)
            return {1'b1, hi};
        else
            return {1'b0, sum[13:0]};
    endfunction

endpackage

// File: rtl/vel_integrator.sv
// Purpose: one axis of velocity update: v + (accel >>> ACCEL_SHIFT), saturated to +/-VMAX.
// Latency: combinational.
// Backpressure: none.
// Ports: v_in (current velocity, 1/16 px/frame), accel (signed tilt), v_out (new velocity).
module vel_integrator #(
    parameter int VMAX        = 64,
    parameter int ACCEL_SHIFT = 2
) (
    input  logic signed [9:0] v_in,
    input  logic signed [7:0] accel,
    output logic signed [9:0] v_out
);

    localparam logic signed [9:0] VMAX_P = 10'(VMAX);
    localparam logic signed [9:0] VMIN_P = 10'(-VMAX);

    logic signed [9:0] accel_ext;
    logic signed [9:0] sum;

    assign accel_ext = $signed({{2{accel[7]}}, accel}) >>> ACCEL_SHIFT;
    // |v_in| <= VMAX and |accel_ext| <= 32, so 10 bits cannot overflow here.
    assign sum = v_in + accel_ext;

    always_comb begin
        v_out = sum;
        if (sum > VMAX_P)
            v_out = VMAX_P;
        else if (sum < VMIN_P)
            v_out = VMIN_P;
    end

endmodule

// File: rtl/ball_physics.sv
// Purpose: per-frame ball motion: tilt->velocity->position, wall/hole/goal resolution via map reads.
// Latency: 10 cycles from accepted frame_start to ball_loc update (8 when an axis does not move).
// Backpressure: none; frame_start while busy or after a win is dropped, map_tile assumed valid 1 cycle after map_req.
// Ports: sys_clk/sys_rst (sync active-high), frame_start, accel_x/accel_y (signed tilt),
//        map_req/map_tile_x/map_tile_y -> map, map_tile <- map, ball_loc_X/ball_loc_Y, won_the_game, busy.
module ball_physics
    import labyrinth_pkg::*;
#(
    parameter int START_X     = 24,
    parameter int START_Y     = 24,
    parameter int BALL_SIZE   = 8,
    parameter int VMAX        = 64,
    parameter int ACCEL_SHIFT = 2,
    parameter int TILE_SHIFT  = 4
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       frame_start,
    input  logic [7:0] accel_x,
    input  logic [7:0] accel_y,
    output logic       map_req,
    output logic [5:0] map_tile_x,
    output logic [4:0] map_tile_y,
    input  logic [1:0] map_tile,
    output logic [9:0] ball_loc_X,
    output logic [9:0] ball_loc_Y,
    output logic       won_the_game,
    output logic       busy
);

    localparam int          TX_W       = $clog2(MAP_COLS);
    localparam int          TY_W       = $clog2(MAP_ROWS);
    localparam logic [9:0]  BALL_M1    = 10'(BALL_SIZE - 1);
    localparam logic [9:0]  BALL_HALF  = 10'(BALL_SIZE / 2);
    localparam logic [13:0] MAX_X      = 14'((SCREEN_W - BALL_SIZE) << 4);
    localparam logic [13:0] MAX_Y      = 14'((SCREEN_H - BALL_SIZE) << 4);
    localparam logic [13:0] START_X_FP = 14'(START_X << 4);
    localparam logic [13:0] START_Y_FP = 14'(START_Y << 4);

    state_t state, state_nxt;

    // Positions are 10.4 fixed point; velocities are signed 1/16 px per frame.
    logic [13:0]       pos_x, pos_y;
    logic [13:0]       cand_x, cand_y;
    logic signed [9:0] vx, vy;
    logic signed [9:0] vx_new, vy_new;
    logic [14:0]       step_x, step_y;
    logic              wall_first;

    logic [9:0] pos_x_int, pos_y_int;
    logic [9:0] edge_x, edge_y;
    logic [9:0] probe_px, probe_py;

    vel_integrator #(.VMAX(VMAX), .ACCEL_SHIFT(ACCEL_SHIFT)) u_vel_x (
        .v_in  (vx),
        .accel (accel_x),
        .v_out (vx_new)
    );

    vel_integrator #(.VMAX(VMAX), .ACCEL_SHIFT(ACCEL_SHIFT)) u_vel_y (
        .v_in  (vy),
        .accel (accel_y),
        .v_out (vy_new)
    );

    assign step_x = axis_step(pos_x, vx_new, MAX_X);
    assign step_y = axis_step(pos_y, vy_new, MAX_Y);

    assign pos_x_int = pos_x[13:4];
    assign pos_y_int = pos_y[13:4];

    // Leading edge follows the direction of the (possibly clamped) move
    // rather than the sign of v, since a clamp zeroes v but may still move.
    assign edge_x = (cand_x > pos_x) ? cand_x[13:4] + BALL_M1 : cand_x[13:4];
    assign edge_y = (cand_y > pos_y) ? cand_y[13:4] + BALL_M1 : cand_y[13:4];

    assign map_tile_x = TX_W'(probe_px >> TILE_SHIFT);
    assign map_tile_y = TY_W'(probe_py >> TILE_SHIFT);
    assign busy       = (state != IDLE);

    always_ff @(posedge sys_clk) begin
        if (sys_rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        map_req   = 1'b0;
        probe_px  = '0;
        probe_py  = '0;
        case (state)
            IDLE: if (frame_start && !won_the_game) state_nxt = VEL;
            // An axis whose candidate equals its position has nothing to probe.
            VEL:  state_nxt = (step_x[13:0] != pos_x) ? QX0 : WX;
            QX0: begin
                map_req   = 1'b1;
                probe_px  = edge_x;
                probe_py  = pos_y_int;
                state_nxt = QX1;
            end
            QX1: begin
                map_req   = 1'b1;
                probe_px  = edge_x;
                probe_py  = pos_y_int + BALL_M1;
                state_nxt = WX;
            end
            WX:   state_nxt = (cand_y != pos_y) ? QY0 : WY;
            QY0: begin
                map_req   = 1'b1;
                probe_px  = pos_x_int;
                probe_py  = edge_y;
                state_nxt = QY1;
            end
            QY1: begin
                map_req   = 1'b1;
                probe_px  = pos_x_int + BALL_M1;
                probe_py  = edge_y;
                state_nxt = WY;
            end
            WY:   state_nxt = QC;
            QC: begin
                map_req   = 1'b1;
                probe_px  = pos_x_int + BALL_HALF;
                probe_py  = pos_y_int + BALL_HALF;
                state_nxt = RC;
            end
            RC:   state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pos_x        <= START_X_FP;
            pos_y        <= START_Y_FP;
            cand_x       <= START_X_FP;
            cand_y       <= START_Y_FP;
            vx           <= '0;
            vy           <= '0;
            wall_first   <= 1'b0;
            won_the_game <= 1'b0;
            ball_loc_X   <= 10'(START_X);
            ball_loc_Y   <= 10'(START_Y);
        end else begin
            case (state)
                VEL: begin
                    vx     <= step_x[14] ? '0 : vx_new;
                    vy     <= step_y[14] ? '0 : vy_new;
                    cand_x <= step_x[13:0];
                    cand_y <= step_y[13:0];
                end
                // map_tile here answers the first probe of the pair.
                QX1, QY1: wall_first <= (map_tile == TILE_WALL);
                WX: if (cand_x != pos_x) begin
                    if (wall_first || map_tile == TILE_WALL)
                        vx <= '0;
                    else
                        pos_x <= cand_x;
                end
                WY: if (cand_y != pos_y) begin
                    if (wall_first || map_tile == TILE_WALL)
                        vy <= '0;
                    else
                        pos_y <= cand_y;
                end
                RC: case (map_tile)
                    TILE_HOLE: begin
                        pos_x <= START_X_FP;
                        pos_y <= START_Y_FP;
                        vx    <= '0;
                        vy    <= '0;
                    end
                    TILE_GOAL: begin
                        won_the_game <= 1'b1;
                        vx           <= '0;
                        vy           <= '0;
                    end
                    default: ;
                endcase
                DONE: begin
                    ball_loc_X <= pos_x_int;
                    ball_loc_Y <= pos_y_int;
                end
                default: ;
            endcase
        end
    end

endmodule
